// File: rtl/dds_wave_core.sv
// DDS front-end: 32-bit phase accumulator, 4-key debouncer with press pulses and
// rectangular wave lookup. Define REC_DUTY_EN to add the runtime duty threshold input.
module dds_wave_core #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACC_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_WIDTH-1:0] freqctrl,
  input  logic [3:0]           key_in,
`ifdef REC_DUTY_EN
  input  logic [7:0]           duty,
`endif
  output logic [7:0]           addr,
  output logic [7:0]           rec_q,
  output logic [3:0]           key_flag
);

  localparam int NUM_KEYS = 4;
  localparam int CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Phase accumulator: wraps silently modulo 2^ACC_WIDTH.
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

  assign acc_d = acc_q + freqctrl;
  assign addr  = acc_q[ACC_WIDTH-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Rectangular lookup with registered read, one clock behind addr.
  // ---------------------------------------------------------------------------
  logic [7:0] rec_thr;
  logic [7:0] rec_d;

`ifdef REC_DUTY_EN
  assign rec_thr = duty;
`else
  assign rec_thr = 8'd128;
`endif

  assign rec_d = (addr < rec_thr) ? 8'd255 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= 8'd0;
    end else begin
      rec_q <= rec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debouncer. The counter runs only while the synchronised level
  // disagrees with the debounced state; any agreement restarts it.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic             sync1_q;
      logic             sync2_q;
      logic             db_q;
      logic             db_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             flag_q;
      logic             flag_d;
      logic             pending;
      logic             accept;

      assign pending = (sync2_q != db_q);
      assign accept  = pending && (cnt_q == CNT_MAX);
      assign cnt_d   = (!pending || accept) ? '0 : cnt_q + CNT_W'(1);
      assign db_d    = accept ? sync2_q : db_q;
      // Only the 1->0 (press) direction is reported.
      assign flag_d  = accept && !sync2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          db_q    <= 1'b1;
          cnt_q   <= '0;
          flag_q  <= 1'b0;
        end else begin
          sync1_q <= key_in[gi];
          sync2_q <= sync1_q;
          db_q    <= db_d;
          cnt_q   <= cnt_d;
          flag_q  <= flag_d;
        end
      end

      assign key_flag[gi] = flag_q;
    end
  endgenerate

endmodule

// File: tb/tb_dds_wave_core.sv
// Self-checking bench for dds_wave_core: directed sweeps, key scenarios and
// randomized segments checked every clock against a behavioural model.
module tb_dds_wave_core;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] freqctrl = '0;
  logic [3:0]  key_in = 4'hF;
  logic [7:0]  addr;
  logic [7:0]  rec_q;
  logic [3:0]  key_flag;

  dds_wave_core #(
    .DEBOUNCE_CYCLES(N),
    .ACC_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .freqctrl(freqctrl),
    .key_in(key_in),
    .addr(addr),
    .rec_q(rec_q),
    .key_flag(key_flag)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state: phase as plain integer, raw key history window.
  longint     m_phase;
  int         m_rec;
  logic [3:0] m_db;
  logic [3:0] m_flag;
  logic [3:0] hist[$];

  int         cyc = 0;
  int         pulse_cnt = 0;
  int         last_pulse_cyc = -1;
  logic [3:0] last_pulse_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_rec   = 0;
    m_db    = 4'hF;
    m_flag  = 4'h0;
    hist.delete();
    for (int i = 0; i < N + 2; i++) hist.push_back(4'hF);
  endfunction

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input logic [31:0] fc, input logic [3:0] k);
    logic [3:0] h;
    bit         all_opp;
    freqctrl = fc;
    key_in   = k;
    @(posedge clk);
    cyc++;
    m_rec   = ((m_phase / 64'd16777216) < 128) ? 255 : 0;
    m_phase = (m_phase + longint'(fc)) % 64'h1_0000_0000;
    hist.push_back(k);
    void'(hist.pop_front());
    // A key level is accepted once N consecutive raw samples, ending two
    // clocks ago (synchroniser delay), all oppose the debounced level.
    m_flag = 4'h0;
    for (int b = 0; b < 4; b++) begin
      all_opp = 1'b1;
      for (int j = 0; j < N; j++) begin
        h = hist[j];
        if (h[b] == m_db[b]) all_opp = 1'b0;
      end
      if (all_opp) begin
        m_db[b] = ~m_db[b];
        if (m_db[b] == 1'b0) m_flag[b] = 1'b1;
      end
    end
    #1;
    chk("addr", 64'(addr), 64'(m_phase / 64'd16777216));
    chk("rec_q", 64'(rec_q), 64'(m_rec));
    chk("key_flag", 64'(key_flag), 64'(m_flag));
    if (key_flag !== 4'h0) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      last_pulse_val = key_flag;
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    chk("rst_addr_now", 64'(addr), 64'd0);
    chk("rst_rec_now", 64'(rec_q), 64'd0);
    chk("rst_flag_now", 64'(key_flag), 64'd0);
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_addr_hold", 64'(addr), 64'd0);
    chk("rst_rec_hold", 64'(rec_q), 64'd0);
    chk("rst_flag_hold", 64'(key_flag), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int          t0;
    int          len;
    logic [31:0] fc;
    logic [3:0]  k;

    model_reset();
    #2;
    apply_reset(3);

    // Full sweep: one address step per clock, wraps after 256.
    repeat (260) step(32'h0100_0000, 4'hF);
    chk("sweep_wrap_addr", 64'(addr), 64'd4);

    // Zero increment freezes the phase.
    repeat (20) step(32'h0, 4'hF);
    chk("freeze_addr", 64'(addr), 64'd4);

    // key_in[2] held low 40 clocks: one pulse, fixed latency.
    fc = 32'h0031_0A5B;
    pulse_cnt = 0;
    t0 = cyc + 1;
    repeat (40) step(fc, 4'b1011);
    chk("k2_pulse_count", 64'(pulse_cnt), 64'd1);
    chk("k2_pulse_value", 64'(last_pulse_val), 64'h4);
    chk("k2_pulse_latency", 64'(last_pulse_cyc - t0), 64'(N + 1));
    pulse_cnt = 0;
    repeat (40) step(fc, 4'hF);
    chk("k2_release_no_pulse", 64'(pulse_cnt), 64'd0);

    // key_in[1] bouncing every 5 clocks: never accepted.
    pulse_cnt = 0;
    for (int i = 0; i < 100; i++) step(fc, ((i / 5) % 2 == 0) ? 4'b1101 : 4'b1111);
    repeat (30) step(fc, 4'hF);
    chk("k1_bounce_no_pulse", 64'(pulse_cnt), 64'd0);

    // key_in[3] and key_in[1] fall together.
    pulse_cnt = 0;
    repeat (30) step(fc, 4'b0101);
    chk("k31_pulse_count", 64'(pulse_cnt), 64'd1);
    chk("k31_pulse_value", 64'(last_pulse_val), 64'hA);
    repeat (30) step(fc, 4'hF);

    // Reset mid-sweep and mid-debounce on key_in[0].
    repeat (10) step(32'h0123_4567, 4'b1110);
    apply_reset(3);
    pulse_cnt = 0;
    t0 = cyc + 1;
    repeat (30) step(32'h0123_4567, 4'b1110);
    chk("rst_key_pulse_count", 64'(pulse_cnt), 64'd1);
    chk("rst_key_pulse_value", 64'(last_pulse_val), 64'h1);
    chk("rst_key_pulse_latency", 64'(last_pulse_cyc - t0), 64'(N + 1));
    repeat (30) step(32'h0123_4567, 4'hF);

    // Randomized segments of increment and key levels.
    for (int s = 0; s < 80; s++) begin
      fc  = $urandom;
      k   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 40);
      repeat (len) step(fc, k);
    end
    repeat (N + 4) step(32'h0100_0000, 4'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
